stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Control front-end for the millisecond counter.
- Synchronises and debounces the raw start/stop and clear buttons and runs an IDLE/RUN/PAUSE state machine.
- Generates a 1 ms enable tick that drives the EN input of the downstream counter flip-flop chain, plus a one-cycle clear pulse for that chain.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- TICK_HZ, 1000, EN tick rate. TICK_DIV = CLK_FREQ_HZ/TICK_HZ; must be an integer >= 2.
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a button level change; >= 2.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- BTN_SS  in  1  raw start/stop button; asynchronous, active-high.
- BTN_CLR  in  1  raw clear button; asynchronous, active-high.
- EN  out  1  one-cycle count-enable pulse, once per tick period while RUN.
- CLR  out  1  one-cycle clear pulse to the counter chain.
- RUNNING  out  1  high while state = RUN.

Behaviour:
- Reset (RST high at rising CLK):
  - state = IDLE; EN = 0, CLR = 0, RUNNING = 0.
  - Synchronisers, debounced levels, debounce counters and prescaler all = 0.
  - Reset mid-operation aborts any run or pending debounce immediately.
- Synchronisation: each button passes through a 2-flop synchroniser.
- Debounce, per button:
  - Counter, width clog2(DB_CYCLES).
  - If synced input != debounced level: counter increments.
  - If they are equal: counter returns to 0.
  - When counter = DB_CYCLES-1 and still differing: debounced level toggles on the next edge and counter returns to 0.
  - Any glitch shorter than DB_CYCLES cycles has no effect.
- Press pulse: registered rising-edge detect of the debounced level, high for exactly 1 cycle.
  - Total latency from raw edge to press pulse = DB_CYCLES + 3 cycles.
  - Release produces no pulse.
- Prescaler:
  - Counter 0..TICK_DIV-1; increments only in RUN, holds in PAUSE.
  - Forced to 0 in IDLE and on every IDLE->RUN transition.
  - Terminal count (= TICK_DIV-1) in RUN: EN = 1 that cycle, counter wraps to 0.
  - First EN is asserted exactly TICK_DIV cycles after RUNNING rises.
  - PAUSE/resume keeps the partial period, so no time is lost or gained.
- FSM transitions (registered; new state is visible the cycle after the press pulse):
  - IDLE: ss press -> RUN. clr press -> stay IDLE and pulse CLR.
  - RUN: ss press -> PAUSE. clr press is ignored.
  - PAUSE: ss press -> RUN. clr press -> IDLE and pulse CLR.
- Simultaneous ss and clr press in the same cycle:
  - In RUN: ss wins -> PAUSE.
  - In IDLE or PAUSE: clr wins -> IDLE with CLR pulse; ss is discarded.
- EN on a RUN->PAUSE edge: EN may be asserted in the same cycle as the ss press pulse if the prescaler is at terminal count, because state is still RUN. No EN after that.
- Output registration:
  - CLR is registered: 1 cycle, asserted in the cycle after the clr press pulse.
  - EN and CLR are never both high in the same cycle.
  - RUNNING = (state == RUN), registered.

Optional Feature:
- Macro: STOPWATCH_LAP_EN.
- Defined:
  - Adds input BTN_LAP (same sync/debounce path) and output HOLD (1 bit, reset 0).
  - Lap press in RUN toggles HOLD; it is ignored in IDLE and PAUSE.
  - HOLD clears to 0 on the CLR pulse and on entry to IDLE.
  - EN and counting are unaffected by HOLD; it only freezes the display.
- Undefined: no BTN_LAP or HOLD ports, no lap logic; behaviour otherwise identical.

Test Plan:
- Bench parameters: CLK_FREQ_HZ=1000, TICK_HZ=100 (TICK_DIV=10), DB_CYCLES=4.
- Reset: assert RST 3 cycles with buttons held high -> EN=0, CLR=0, RUNNING=0 during and after; no press pulse until buttons are released and re-pressed.
- Debounce: BTN_SS pulses of 1, 2 and 3 cycles -> no state change. A 10-cycle hold -> RUNNING rises exactly 8 cycles after the raw edge (DB_CYCLES+3 to the press pulse, +1 registered state). First EN follows 10 cycles later, then every 10 cycles.
- Pause/resume: start, pause with prescaler at 6, wait 50 cycles, resume -> first EN arrives 4 cycles after RUNNING re-rises; total EN count equals RUN cycles/10.
- Clear: clr pressed in RUN -> ignored, EN continues. clr pressed in PAUSE -> one CLR pulse, state IDLE, RUNNING=0, prescaler=0.
- Simultaneous: both buttons pressed identically in RUN -> PAUSE, no CLR. Both pressed in PAUSE -> IDLE plus one CLR pulse, no RUN.
- With STOPWATCH_LAP_EN defined: lap press in RUN -> HOLD=1 while EN keeps pulsing; second lap -> HOLD=0; lap then clr from PAUSE -> HOLD=0 alongside the CLR pulse.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button front-end and run control for the millisecond counter.
// Each button is synchronised, debounced and turned into a one-cycle press
// pulse. An IDLE/RUN/PAUSE machine then drives the 1 ms EN tick and the
// counter-chain CLR pulse.
// Optional lap/hold feature: define STOPWATCH_LAP_EN to add BTN_LAP and HOLD.

// Per-button path: 2-flop synchroniser, debounce counter, registered press pulse.
module stopwatch_btn #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic raw,
  output logic press
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic          s1, s2, db, db_d;
  logic [CW-1:0] cnt;

  // Sync, then accept a level change only after DB_CYCLES stable samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      db    <= 1'b0;
      db_d  <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      db_d  <= db;
      press <= db & ~db_d;
      if (s2 != db) begin
        if (cnt == CW'(DB_CYCLES - 1)) begin
          db  <= ~db;
          cnt <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

module stopwatch_ctrl #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int TICK_HZ     = 1000,
  parameter int DB_CYCLES   = 1000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_SS,
  input  logic BTN_CLR,
`ifdef STOPWATCH_LAP_EN
  input  logic BTN_LAP,
  output logic HOLD,
`endif
  output logic EN,
  output logic CLR,
  output logic RUNNING
);
  localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);
`ifdef STOPWATCH_LAP_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  logic [NB-1:0] raw, press;
  logic          ss_p, clr_p;
  state_t        state, state_nxt;
  logic          clr_nxt;
  logic [PW-1:0] psc;

`ifdef STOPWATCH_LAP_EN
  assign raw = {BTN_LAP, BTN_CLR, BTN_SS};
`else
  assign raw = {BTN_CLR, BTN_SS};
`endif
  assign ss_p  = press[0];
  assign clr_p = press[1];

  for (genvar g = 0; g < NB; g++) begin : g_btn
    stopwatch_btn #(.DB_CYCLES(DB_CYCLES)) u_btn (
      .CLK   (CLK),
      .RST   (RST),
      .raw   (raw[g]),
      .press (press[g])
    );
  end

  // State register plus registered CLR pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      CLR   <= 1'b0;
    end else begin
      state <= state_nxt;
      CLR   <= clr_nxt;
    end
  end

  // Next state; in RUN start/stop outranks clear, elsewhere clear outranks it.
  always_comb begin
    state_nxt = state;
    clr_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (clr_p)     clr_nxt   = 1'b1;
        else if (ss_p) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (ss_p) state_nxt = S_PAUSE;
      end
      S_PAUSE: begin
        if (clr_p) begin
          state_nxt = S_IDLE;
          clr_nxt   = 1'b1;
        end else if (ss_p) begin
          state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Prescaler counts RUN cycles only; PAUSE keeps the partial period.
  always_ff @(posedge CLK) begin
    if (RST) begin
      psc <= '0;
      EN  <= 1'b0;
    end else begin
      EN <= (state == S_RUN) && (psc == PW'(TICK_DIV - 1));
      if (state == S_RUN)       psc <= (psc == PW'(TICK_DIV - 1)) ? '0 : psc + 1'b1;
      else if (state == S_IDLE) psc <= '0;
    end
  end

  assign RUNNING = (state == S_RUN);

`ifdef STOPWATCH_LAP_EN
  // Lap toggles the display hold while running; leaving to IDLE drops it.
  always_ff @(posedge CLK) begin
    if (RST)                       HOLD <= 1'b0;
    else if (state_nxt == S_IDLE)  HOLD <= 1'b0;
    else if (state == S_RUN && press[2]) HOLD <= ~HOLD;
  end
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: cycle-by-cycle comparison against a behavioural
// model, plus hand-computed literal checks of the key latencies.
module tb_stopwatch_ctrl;
  localparam int TD = 10;
  localparam int DB = 4;

  logic CLK = 1'b0, RST = 1'b1, BTN_SS = 1'b0, BTN_CLR = 1'b0;
  logic EN, CLR, RUNNING;
  logic lap;
`ifdef STOPWATCH_LAP_EN
  logic BTN_LAP = 1'b0, HOLD;
  assign lap = BTN_LAP;
`else
  assign lap = 1'b0;
`endif

  stopwatch_ctrl #(.CLK_FREQ_HZ(1000), .TICK_HZ(100), .DB_CYCLES(DB)) dut (
    .CLK(CLK), .RST(RST), .BTN_SS(BTN_SS), .BTN_CLR(BTN_CLR),
`ifdef STOPWATCH_LAP_EN
    .BTN_LAP(BTN_LAP), .HOLD(HOLD),
`endif
    .EN(EN), .CLR(CLR), .RUNNING(RUNNING)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0, en_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
  endtask

  // ---------------- behavioural model ----------------
  // A button level is accepted once DB consecutive synchronised samples
  // disagree with it; the FSM sees the press DB+3 cycles after the raw edge.
  // EN fires after every TD cycles spent in RUN, counted since leaving IDLE.
  logic [2:0] btn_now;
  assign btn_now = {lap, BTN_CLR, BTN_SS};

  logic [7:0] m_hist [3] = '{8'd0, 8'd0, 8'd0};
  logic [2:0] m_db = 3'd0, m_db_d = 3'd0, m_prs = 3'd0;
  int   m_state = 0, m_tick = 0;   // 0 idle, 1 run, 2 pause
  logic m_en = 1'b0, m_clr = 1'b0, m_hold = 1'b0;

  function automatic logic settled(input logic [7:0] h, input logic db);
    for (int k = 1; k <= DB; k++) if (h[k] == db) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int fsm_next(input int s, input logic ss, input logic cl);
    if (s == 1) return ss ? 2 : 1;
    if (cl) return 0;
    if (ss) return 1;
    return s;
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      for (int b = 0; b < 3; b++) m_hist[b] <= 8'd0;
      m_db <= 3'd0; m_db_d <= 3'd0; m_prs <= 3'd0;
      m_state <= 0; m_tick <= 0; m_en <= 1'b0; m_clr <= 1'b0; m_hold <= 1'b0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        m_hist[b] <= {m_hist[b][6:0], btn_now[b]};
        m_db[b]   <= settled(m_hist[b], m_db[b]) ? ~m_db[b] : m_db[b];
      end
      m_db_d <= m_db;
      m_prs  <= m_db & ~m_db_d;
      m_state <= fsm_next(m_state, m_prs[0], m_prs[1]);
      m_clr   <= (m_state != 1) && m_prs[1];
      if (m_state == 1) begin
        m_en   <= ((m_tick + 1) % TD) == 0;
        m_tick <= (m_tick + 1) % TD;
      end else begin
        m_en <= 1'b0;
        if (m_state == 0) m_tick <= 0;
      end
      if (fsm_next(m_state, m_prs[0], m_prs[1]) == 0) m_hold <= 1'b0;
      else if (m_state == 1 && m_prs[2])               m_hold <= ~m_hold;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge CLK) begin
    if (cyc > 0) begin
      check("EN", EN, m_en);
      check("CLR", CLR, m_clr);
      check("RUNNING", RUNNING, m_state == 1);
      check("EN_CLR_excl", EN & CLR, 1'b0);
`ifdef STOPWATCH_LAP_EN
      check("HOLD", HOLD, m_hold);
`endif
      if (EN === 1'b1) en_cnt++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic at(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  localparam int S = 70;

  initial begin
    BTN_SS = 1'b1; BTN_CLR = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      at(i);
      check("rst_EN", EN, 1'b0); check("rst_CLR", CLR, 1'b0); check("rst_RUN", RUNNING, 1'b0);
    end
    RST = 1'b0; BTN_SS = 1'b0; BTN_CLR = 1'b0;
    at(20); check("post_rst_RUN", RUNNING, 1'b0);

    // glitches of 1, 2, 3 cycles
    BTN_SS = 1'b1; at(21); BTN_SS = 1'b0;
    at(30); BTN_SS = 1'b1; at(32); BTN_SS = 1'b0;
    at(40); BTN_SS = 1'b1; at(43); BTN_SS = 1'b0;
    at(60); check("glitch_RUN", RUNNING, 1'b0); check("glitch_CLR", CLR, 1'b0);

    // start: RUNNING 8 cycles after raw edge, EN 10 later
    at(S);      BTN_SS = 1'b1;
    at(S+7);    check("start_lat7", RUNNING, 1'b0);
    at(S+8);    check("start_lat8", RUNNING, 1'b1);
    at(S+10);   BTN_SS = 1'b0;
    at(S+17);   check("en1_early", EN, 1'b0);
    at(S+18);   check("en1", EN, 1'b1);
    at(S+19);   check("en1_width", EN, 1'b0);
    at(S+28);   check("en2", EN, 1'b1);

    // pause with prescaler held at 6
    at(S+36);   BTN_SS = 1'b1;
    at(S+38);   check("en3", EN, 1'b1);
    at(S+43);   check("pause_lat7", RUNNING, 1'b1);
    at(S+44);   check("pause_lat8", RUNNING, 1'b0);
    at(S+46);   BTN_SS = 1'b0;
    at(S+48);   check("paused_no_en", EN, 1'b0);

    // resume: EN 4 cycles after RUNNING re-rises
    at(S+94);   BTN_SS = 1'b1;
    at(S+101);  check("resume_lat7", RUNNING, 1'b0);
    at(S+102);  check("resume_lat8", RUNNING, 1'b1);
    at(S+104);  BTN_SS = 1'b0;
    at(S+105);  check("resume_en_early", EN, 1'b0);
    at(S+106);  check("resume_en", EN, 1'b1);
    at(S+111);  check("en_total", en_cnt, 4);

    // clear ignored in RUN
    at(S+120);  BTN_CLR = 1'b1;
    at(S+128);  check("clr_run_RUN", RUNNING, 1'b1); check("clr_run_CLR", CLR, 1'b0);
    at(S+130);  BTN_CLR = 1'b0;
    at(S+136);  check("clr_run_en", EN, 1'b1);

    // pause, then clear from PAUSE
    at(S+140);  BTN_SS = 1'b1;
    at(S+148);  check("pause2", RUNNING, 1'b0);
    at(S+150);  BTN_SS = 1'b0;
    at(S+170);  BTN_CLR = 1'b1;
    at(S+177);  check("clr_early", CLR, 1'b0);
    at(S+178);  check("clr_pulse", CLR, 1'b1); check("clr_idle", RUNNING, 1'b0);
    at(S+179);  check("clr_width", CLR, 1'b0);
    at(S+180);  BTN_CLR = 1'b0;

    // restart from IDLE: prescaler must have been zeroed
    at(S+200);  BTN_SS = 1'b1;
    at(S+208);  check("restart", RUNNING, 1'b1);
    at(S+210);  BTN_SS = 1'b0;
    at(S+217);  check("restart_en_early", EN, 1'b0);
    at(S+218);  check("restart_en", EN, 1'b1);

    // simultaneous press in RUN -> PAUSE, no CLR
    at(S+240);  BTN_SS = 1'b1; BTN_CLR = 1'b1;
    at(S+248);  check("both_run_RUN", RUNNING, 1'b0); check("both_run_CLR", CLR, 1'b0);
    at(S+249);  check("both_run_CLR2", CLR, 1'b0);
    at(S+250);  BTN_SS = 1'b0; BTN_CLR = 1'b0;

    // simultaneous press in PAUSE -> IDLE with CLR, no RUN
    at(S+270);  BTN_SS = 1'b1; BTN_CLR = 1'b1;
    at(S+278);  check("both_pause_CLR", CLR, 1'b1); check("both_pause_RUN", RUNNING, 1'b0);
    at(S+280);  BTN_SS = 1'b0; BTN_CLR = 1'b0;
    at(S+285);  check("both_pause_stay", RUNNING, 1'b0);

`ifdef STOPWATCH_LAP_EN
    at(S+300);  BTN_SS = 1'b1;
    at(S+310);  BTN_SS = 1'b0;
    at(S+320);  BTN_LAP = 1'b1;
    at(S+328);  check("lap_hold_on", HOLD, 1'b1);
    at(S+330);  BTN_LAP = 1'b0;
    at(S+338);  check("lap_en", EN, 1'b1); check("lap_hold_keep", HOLD, 1'b1);
    at(S+350);  BTN_LAP = 1'b1;
    at(S+358);  check("lap_hold_off", HOLD, 1'b0);
    at(S+360);  BTN_LAP = 1'b0;
    at(S+370);  BTN_LAP = 1'b1;
    at(S+378);  check("lap_hold_on2", HOLD, 1'b1);
    at(S+380);  BTN_LAP = 1'b0;
    at(S+390);  BTN_SS = 1'b1;
    at(S+398);  check("lap_paused", RUNNING, 1'b0);
    at(S+400);  BTN_SS = 1'b0;
    at(S+410);  BTN_LAP = 1'b1;
    at(S+418);  check("lap_pause_ignored", HOLD, 1'b1);
    at(S+420);  BTN_LAP = 1'b0;
    at(S+430);  BTN_CLR = 1'b1;
    at(S+437);  check("lap_hold_pre_clr", HOLD, 1'b1);
    at(S+438);  check("lap_clr", CLR, 1'b1); check("lap_hold_clr", HOLD, 1'b0);
    at(S+440);  BTN_CLR = 1'b0;
`endif

    // reset mid-run aborts immediately
    at(S+460);  BTN_SS = 1'b1;
    at(S+468);  check("pre_rst_run", RUNNING, 1'b1);
    at(S+470);  BTN_SS = 1'b0;
    at(S+475);  RST = 1'b1;
    at(S+476);  check("midrst_RUN", RUNNING, 1'b0); check("midrst_EN", EN, 1'b0);
    RST = 1'b0;
    at(S+490);  check("midrst_stay", RUNNING, 1'b0);

    at(S+500);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
